// File: rtl/dap_usb_pkt_receiver.sv
// USB bulk-OUT receiver: packet-atomic byte FIFO streamed out over AXI-Stream.
// Define DAP_USB_RX_TLAST_EN to build the length FIFO and drive axis_tlast.
module dap_usb_pkt_receiver #(
    parameter logic [3:0]  P_ENDPOINT = 4'd2,
    parameter int unsigned P_ADDR_W   = 12,
    parameter int unsigned P_MAX_PKT  = 512,
    parameter int unsigned P_LEN_AW   = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        usb_endpt,
    input  logic              usb_rxact,
    input  logic              usb_rxval,
    input  logic [7:0]        usb_rxdat,
    input  logic              usb_rxpktval,
    output logic              usb_rxrdy,
    output logic [7:0]        axis_tdata,
    output logic              axis_tvalid,
    input  logic              axis_tready,
    output logic              axis_tlast,
    output logic [P_ADDR_W:0] fill_level,
    output logic              pkt_drop
);
    localparam int unsigned DEPTH = 2 ** P_ADDR_W;

    typedef logic [P_ADDR_W:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t MAX_P   = ptr_t'(P_MAX_PKT);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    typedef enum logic {S_IDLE, S_RX} rx_state_t;
    rx_state_t state, state_nxt;

    logic       sel, act, val;
    logic       start, live, fall, byte_en, room_full, ram_we, pv, commit;
    logic       lf_ok;
    ptr_t       wptr, wtmp, rptr, len_q;
    ptr_t       cur_wtmp, cur_len, wtmp_nxt, len_nxt;
    logic       bad_q, cur_bad, bad_nxt;
    logic       closed_q, closed_nxt, drop_nxt;

    logic [7:0] ram [DEPTH];
    logic [7:0] ram_q;
    logic       rd_v, rd_en, avail, s2_free, s1_move;

    assign sel = (usb_endpt == P_ENDPOINT);
    assign act = usb_rxact & sel;
    assign val = usb_rxval & sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // closed_q marks a packet already resolved by rxpktval, so the later
    // falling edge of act neither rolls back nor pulses pkt_drop again.
    always_comb begin
        state_nxt  = act ? S_RX : S_IDLE;
        start      = act && (state == S_IDLE);
        live       = start || ((state == S_RX) && !closed_q);
        fall       = !act && (state == S_RX) && !closed_q;
        cur_wtmp   = start ? wptr : wtmp;
        cur_len    = start ? '0 : len_q;
        cur_bad    = start ? 1'b0 : bad_q;
        byte_en    = val && act && live;
        room_full  = ((cur_wtmp - rptr) == DEPTH_P) || (cur_len == MAX_P);
        ram_we     = byte_en && !room_full;
        wtmp_nxt   = ram_we ? cur_wtmp + PTR_ONE : cur_wtmp;
        len_nxt    = ram_we ? cur_len + PTR_ONE : cur_len;
        bad_nxt    = cur_bad | (byte_en & room_full);
        pv         = usb_rxpktval && sel && live;
        commit     = pv && !bad_nxt && (len_nxt != '0) && lf_ok;
        closed_nxt = start ? pv : (closed_q | pv);
        drop_nxt   = 1'b0;
        if (pv)
            drop_nxt = bad_nxt || ((len_nxt != '0) && !lf_ok);
        else if (fall)
            drop_nxt = (len_nxt != '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr     <= '0;
            wtmp     <= '0;
            len_q    <= '0;
            bad_q    <= 1'b0;
            closed_q <= 1'b0;
            pkt_drop <= 1'b0;
        end else begin
            wtmp     <= wtmp_nxt;
            len_q    <= len_nxt;
            bad_q    <= bad_nxt;
            closed_q <= closed_nxt;
            pkt_drop <= drop_nxt;
            if (commit) wptr <= wtmp_nxt;
        end
    end

    // Two-stage read pipe: RAM read register, then the AXI-Stream output register.
    assign avail   = (wptr != rptr);
    assign s2_free = !axis_tvalid || axis_tready;
    assign s1_move = rd_v && s2_free;
    assign rd_en   = avail && (!rd_v || s1_move);

    always_ff @(posedge clk) begin
        if (ram_we) ram[cur_wtmp[P_ADDR_W-1:0]] <= usb_rxdat;
        if (rd_en)  ram_q <= ram[rptr[P_ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr        <= '0;
            rd_v        <= 1'b0;
            axis_tvalid <= 1'b0;
            axis_tdata  <= '0;
        end else begin
            if (rd_en) rptr <= rptr + PTR_ONE;
            if (rd_en)        rd_v <= 1'b1;
            else if (s1_move) rd_v <= 1'b0;
            if (s1_move) begin
                axis_tvalid <= 1'b1;
                axis_tdata  <= ram_q;
            end else if (axis_tready) begin
                axis_tvalid <= 1'b0;
            end
        end
    end

    assign fill_level = (wptr - rptr) + ptr_t'(rd_v) + ptr_t'(axis_tvalid);
    assign usb_rxrdy  = ((DEPTH_P - (wptr - rptr)) >= MAX_P) && lf_ok;

`ifdef DAP_USB_RX_TLAST_EN
    localparam int unsigned LF_DEPTH = 2 ** P_LEN_AW;
    typedef logic [P_LEN_AW:0] lptr_t;
    localparam lptr_t LF_DEPTH_P = lptr_t'(LF_DEPTH);
    localparam lptr_t LPTR_ONE   = lptr_t'(1);

    ptr_t  len_fifo [LF_DEPTH];
    lptr_t lf_wptr, lf_lptr, lf_rptr;
    ptr_t  tl_cnt, lf_head;
    logic  tlast_q;

    // lf_lptr loads the counter ahead of lf_rptr, which frees the entry only
    // once the tlast byte has actually been accepted downstream.
    assign lf_ok   = (lf_wptr - lf_rptr) != LF_DEPTH_P;
    assign lf_head = len_fifo[lf_lptr[P_LEN_AW-1:0]];

    always_ff @(posedge clk) begin
        if (commit) len_fifo[lf_wptr[P_LEN_AW-1:0]] <= len_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lf_wptr <= '0;
            lf_lptr <= '0;
            lf_rptr <= '0;
            tl_cnt  <= '0;
            tlast_q <= 1'b0;
        end else begin
            if (commit) lf_wptr <= lf_wptr + LPTR_ONE;
            if (axis_tvalid && axis_tready && tlast_q) lf_rptr <= lf_rptr + LPTR_ONE;
            if (s1_move) begin
                if (tl_cnt == '0) begin
                    tlast_q <= (lf_head == PTR_ONE);
                    tl_cnt  <= lf_head - PTR_ONE;
                    lf_lptr <= lf_lptr + LPTR_ONE;
                end else begin
                    tlast_q <= (tl_cnt == PTR_ONE);
                    tl_cnt  <= tl_cnt - PTR_ONE;
                end
            end else if (axis_tready) begin
                tlast_q <= 1'b0;
            end
        end
    end

    assign axis_tlast = tlast_q;
`else
    assign lf_ok      = 1'b1;
    assign axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_dap_usb_pkt_receiver.sv
// Scoreboard bench for dap_usb_pkt_receiver: randomized packets checked
// against a queue-level packet model (commit/drop rules, byte order, tlast).
`timescale 1ns/1ps
module tb_dap_usb_pkt_receiver;
    localparam int unsigned AW    = 10;
    localparam int unsigned MAX   = 512;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [3:0]  EP    = 4'd2;
`ifdef DAP_USB_RX_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic [3:0]    usb_endpt;
    logic          usb_rxact, usb_rxval, usb_rxpktval, usb_rxrdy;
    logic [7:0]    usb_rxdat;
    logic [7:0]    axis_tdata;
    logic          axis_tvalid, axis_tready, axis_tlast, pkt_drop;
    logic [AW:0]   fill_level;

    dap_usb_pkt_receiver #(
        .P_ENDPOINT (EP),
        .P_ADDR_W   (AW),
        .P_MAX_PKT  (MAX),
        .P_LEN_AW   (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .usb_endpt    (usb_endpt),
        .usb_rxact    (usb_rxact),
        .usb_rxval    (usb_rxval),
        .usb_rxdat    (usb_rxdat),
        .usb_rxpktval (usb_rxpktval),
        .usb_rxrdy    (usb_rxrdy),
        .axis_tdata   (axis_tdata),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tlast   (axis_tlast),
        .fill_level   (fill_level),
        .pkt_drop     (pkt_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    longint      committed_bytes = 0;
    longint      accepted_bytes = 0;
    int          drops_exp = 0;
    int          drops_seen = 0;
    int unsigned cyc = 0;
    int unsigned commit_cyc = 0;
    int unsigned rise_cyc = 0;
    int          ready_mode = 0;
    logic [7:0]  pkt_buf [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    // tready driver: 0 = stall, 1 = always ready, 2 = random 50%
    initial begin
        axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       axis_tready = 1'b0;
                1:       axis_tready = 1'b1;
                default: axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted beat, checks stall hold.
    initial begin
        logic       prev_stall, prev_valid, prev_last;
        logic [7:0] prev_data;
        beat_t      e;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        prev_last  = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {axis_tvalid, axis_tdata, axis_tlast},
                        {1'b1, prev_data, prev_last});
                if (axis_tvalid && !prev_valid) rise_cyc = cyc;
                if (axis_tvalid && axis_tready) begin
                    accepted_bytes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexpected: got 0x%0h required no beat", axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {axis_tdata, axis_tlast}, {e.data, e.last});
                    end
                end
                if (pkt_drop) drops_seen++;
                prev_stall = axis_tvalid && !axis_tready;
                prev_valid = axis_tvalid;
                prev_data  = axis_tdata;
                prev_last  = axis_tlast;
            end
        end
    end

    initial begin
        #600000;
        checks++;
        failures++;
        $display("FAIL watchdog: got timeout required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic fill_buf(input int n, input bit ramp);
        for (int i = 0; i < n; i++) pkt_buf[i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    // Model: a packet on our endpoint with pktval and 1..MAX bytes is delivered
    // intact; any other non-empty packet is discarded with one pkt_drop.
    task automatic model_close(input logic [3:0] ep, input int n, input bit commit);
        beat_t b;
        if (ep == EP) begin
            if (commit && n > 0 && n <= MAX) begin
                for (int i = 0; i < n; i++) begin
                    b.data = pkt_buf[i];
                    b.last = TL && (i == n - 1);
                    exp_q.push_back(b);
                end
                committed_bytes += n;
            end else if (n > 0) begin
                drops_exp++;
            end
        end
    endtask

    task automatic send_pkt(input logic [3:0] ep, input int n, input bit commit,
                            input bit pv_last, input bit gaps);
        int g;
        g = 0;
        while (!usb_rxrdy && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!usb_rxrdy) begin
            checks++;
            failures++;
            $display("FAIL rxrdy_wait: got 0 required 1 within 5000 cycles");
        end
        usb_endpt = ep;
        usb_rxact = 1'b1;
        for (int i = 0; i < n; i++) begin
            usb_rxval    = 1'b1;
            usb_rxdat    = pkt_buf[i];
            usb_rxpktval = commit && pv_last && (i == n - 1);
            @(posedge clk);
            #1;
            usb_rxval    = 1'b0;
            usb_rxpktval = 1'b0;
            if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        if (commit && !(pv_last && n > 0)) begin
            usb_rxpktval = 1'b1;
            @(posedge clk);
            #1;
            usb_rxpktval = 1'b0;
        end
        commit_cyc = cyc;
        model_close(ep, n, commit);
        usb_rxact = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || axis_tvalid) && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (exp_q.size() != 0 || axis_tvalid) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d beats outstanding required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        longint tgt;
        logic   rdy0;
        longint fill0;
        int     g;
        resetn = 1'b0;
        usb_endpt = '0;
        usb_rxact = 1'b0;
        usb_rxval = 1'b0;
        usb_rxdat = '0;
        usb_rxpktval = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rxrdy", usb_rxrdy, 1);
        chk("reset_tvalid", axis_tvalid, 0);
        chk("reset_tdata", axis_tdata, 0);
        chk("reset_tlast", axis_tlast, 0);
        chk("reset_fill", fill_level, 0);
        chk("reset_drop", pkt_drop, 0);

        // 64-byte ramp, streaming out at full rate
        ready_mode = 1;
        fill_buf(64, 1'b1);
        send_pkt(EP, 64, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("first_latency", longint'(rise_cyc) - longint'(commit_cyc), 2);
        chk("ramp_fill", fill_level, 0);
        chk("ramp_drops", drops_seen, drops_exp);

        // aborted 10-byte packet, then a 5-byte packet
        fill_buf(10, 1'b0);
        send_pkt(EP, 10, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_drops", drops_seen, drops_exp);
        chk("abort_fill", fill_level, 0);
        fill_buf(5, 1'b0);
        send_pkt(EP, 5, 1'b1, 1'b1, 1'b0);
        wait_drain();
        chk("after_abort_fill", fill_level, 0);

        // fill to capacity with two max packets, stalled output
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        fill_buf(MAX, 1'b0);
        send_pkt(EP, MAX, 1'b1, 1'b0, 1'b0);
        chk("full_a_rxrdy", usb_rxrdy, 1);
        chk("full_a_fill", fill_level, committed_bytes - accepted_bytes);
        fill_buf(MAX, 1'b0);
        send_pkt(EP, MAX, 1'b1, 1'b1, 1'b0);
        chk("full_b_rxrdy", usb_rxrdy, 0);
        chk("full_b_fill", fill_level, DEPTH);
        repeat (5) @(posedge clk);
        #1;
        chk("full_stall_rxrdy", usb_rxrdy, 0);
        tgt = accepted_bytes + MAX;
        ready_mode = 1;
        g = 0;
        while (accepted_bytes < tgt && g < 5000) begin
            @(negedge clk);
            g++;
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("full_read_rxrdy", usb_rxrdy, 1);
        chk("full_read_fill", fill_level, committed_bytes - accepted_bytes);
        fill_buf(MAX, 1'b0);
        send_pkt(EP, MAX, 1'b1, 1'b0, 1'b1);
        chk("wrap_fill", fill_level, committed_bytes - accepted_bytes);
        ready_mode = 1;
        wait_drain();
        chk("wrap_drain_fill", fill_level, 0);

        // oversize packet
        fill0 = fill_level;
        fill_buf(MAX + 1, 1'b0);
        send_pkt(EP, MAX + 1, 1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("oversize_drops", drops_seen, drops_exp);
        chk("oversize_fill", fill_level, fill0);

        // foreign endpoint
        rdy0 = usb_rxrdy;
        fill0 = fill_level;
        fill_buf(8, 1'b0);
        send_pkt(4'd1, 8, 1'b1, 1'b0, 1'b0);
        send_pkt(4'd1, 8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("ep1_drops", drops_seen, drops_exp);
        chk("ep1_rxrdy", usb_rxrdy, rdy0);
        chk("ep1_fill", fill_level, fill0);
        chk("ep1_tvalid", axis_tvalid, 0);

        // random backpressure: 1,3,7 back-to-back, then random traffic
        ready_mode = 2;
        fill_buf(1, 1'b0);
        send_pkt(EP, 1, 1'b1, 1'b1, 1'b0);
        fill_buf(3, 1'b0);
        send_pkt(EP, 3, 1'b1, 1'b0, 1'b0);
        fill_buf(7, 1'b0);
        send_pkt(EP, 7, 1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 25; p++) begin
            int n;
            n = int'($urandom_range(0, 40));
            fill_buf(n, 1'b0);
            send_pkt(EP, n, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain();
        chk("random_drops", drops_seen, drops_exp);
        chk("random_fill", fill_level, 0);

        // reset in the middle of a read and of a packet
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        fill_buf(5, 1'b0);
        send_pkt(EP, 5, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_tvalid", axis_tvalid, 1);
        usb_endpt = EP;
        usb_rxact = 1'b1;
        for (int i = 0; i < 3; i++) begin
            usb_rxval = 1'b1;
            usb_rxdat = 8'($urandom);
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        usb_rxact = 1'b0;
        usb_rxval = 1'b0;
        exp_q.delete();
        #2;
        chk("mid_reset_tvalid", axis_tvalid, 0);
        chk("mid_reset_fill", fill_level, 0);
        chk("mid_reset_drop", pkt_drop, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        committed_bytes = accepted_bytes;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_rxrdy", usb_rxrdy, 1);
        chk("post_reset_drops", drops_seen, drops_exp);
        ready_mode = 1;
        fill_buf(3, 1'b0);
        send_pkt(EP, 3, 1'b1, 1'b1, 1'b0);
        wait_drain();
        chk("post_reset_fill", fill_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dap_usb_pkt_receiver.md
# dap_usb_pkt_receiver

Parametrised USB bulk-OUT receiver for the DAP controller. It captures bytes from the USB device core for one endpoint into a packet-atomic FIFO and streams them to the DAP command parser over AXI-Stream. A packet becomes visible only when the core signals it valid. Incomplete, oversize and overflowing packets are rolled back. Optionally it tags the last byte of each packet with `axis_tlast`.

## Interface
- `P_ENDPOINT`, 4'd2: USB endpoint number served.
- `P_ADDR_W`, 12: data RAM address width; depth is 2^P_ADDR_W bytes.
- `P_MAX_PKT`, 512: maximum packet length in bytes. Must satisfy P_MAX_PKT <= 2^P_ADDR_W.
- `P_LEN_AW`, 3: length-FIFO address width (2^P_LEN_AW packets). Used only with TLAST enabled.
- `clk` in 1: system clock; all logic is on this edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `usb_endpt` in 4: endpoint of the current transfer.
- `usb_rxact` in 1: OUT transaction active.
- `usb_rxval` in 1: `usb_rxdat` valid this cycle.
- `usb_rxdat` in 8: received byte.
- `usb_rxpktval` in 1: one-cycle pulse; packet CRC good, commit.
- `usb_rxrdy` out 1: space available for one full packet; the core NAKs when low.
- `axis_tdata` out 8: output byte.
- `axis_tvalid` out 1: output valid.
- `axis_tready` in 1: downstream accept.
- `axis_tlast` out 1: last byte of packet (0 when feature is compiled out).
- `fill_level` out P_ADDR_W+1: committed bytes not yet read, including the output register.
- `pkt_drop` out 1: one-cycle pulse when a packet is discarded.

## Operation
- `sel` = (usb_endpt == P_ENDPOINT). `act` = usb_rxact & sel. `val` = usb_rxval & sel.
- Pointers `wptr`, `wtmp` and `rptr` are each P_ADDR_W+1 bits wide with a wrap bit. Subtraction is modulo 2^(P_ADDR_W+1).
- Start of packet (rising edge of `act`): `wtmp` ← `wptr`, `len` ← 0, `bad` ← 0. If `val` is high in the same cycle, the byte is written at `wptr` and `wtmp` ← `wptr`+1.
- While the packet is being received, each `val` byte does the following:
  - If (`wtmp` − `rptr`) == 2^P_ADDR_W or `len` == P_MAX_PKT: the byte is dropped and `bad` ← 1.
  - Otherwise: ram[`wtmp`] ← `usb_rxdat`, `wtmp`++, `len`++.
- On `usb_rxpktval` & `sel`: a byte with `val` in the same cycle is counted first.
  - If `bad` = 0 and `len` > 0: commit with `wptr` ← `wtmp`. With TLAST enabled, also push `len` to the length FIFO.
  - If `bad` = 1: discard and pulse `pkt_drop`.
  - If `len` = 0 (ZLP): ignore, no pulse.
- Falling edge of `act` without a commit: implicit rollback. `wtmp` is never used, and the next start reloads it. If `len` > 0, pulse `pkt_drop`.
- `usb_rxrdy` = (2^P_ADDR_W − (`wptr` − `rptr`) ≥ P_MAX_PKT). With TLAST enabled, the length FIFO must also not be full.
- Output stage:
  - Synchronous-read RAM feeds a single output register.
  - Sustains one byte per cycle while `axis_tready` = 1.
  - `axis_tdata` and `axis_tvalid` are held stable while `axis_tvalid` & !`axis_tready`.
- TLAST: a down-counter loads from the length-FIFO head. `axis_tlast` = 1 on the byte where the count reaches 1. Popping the length FIFO happens on the accepted tlast byte.

## Timing
- Reset values: `usb_rxrdy`=1 after reset release (combinational on empty FIFO), `axis_tvalid`=0, `axis_tdata`=0, `axis_tlast`=0, `fill_level`=0, `pkt_drop`=0. All pointers and counters are 0.
- Latency: a commit at edge N gives `axis_tvalid`=1 after edge N+2 carrying the first byte.
- Commit and read in the same cycle are both honoured. `fill_level` reflects both.
- `usb_rxrdy` updates the cycle after a commit or read.
- Pointer wrap at 2^P_ADDR_W is seamless. Full is detected by the wrap bit.
- Reset mid-packet or mid-read discards all contents, with no `pkt_drop` pulse.

## Configuration
- `DAP_USB_RX_TLAST_EN`:
  - Defined: the length FIFO (2^P_LEN_AW entries) and the tlast counter are built. `axis_tlast` marks packet ends. `usb_rxrdy` also requires length-FIFO space.
  - Undefined: no length FIFO is built, `axis_tlast` is tied 0, and P_LEN_AW is ignored.

## Test plan
- After reset, a 64-byte packet 0x00..0x3F with pktval, and tready=1: 64 bytes out in order. tvalid rises two cycles after commit. tlast only on 0x3F (TLAST_EN). `fill_level` returns to 0.
- A 10-byte packet with rxact dropped and no pktval: no output, one `pkt_drop` pulse. The next 5-byte packet outputs exactly those 5 bytes.
- P_ADDR_W=10, P_MAX_PKT=512, tready=0, then two 512-byte packets: `usb_rxrdy` goes 0 after the second commit and returns to 1 after 512 bytes are read. The third packet wraps the pointers correctly.
- A 513-byte packet at P_MAX_PKT=512: discarded, `pkt_drop` pulse, `fill_level` unchanged.
- Random tready at 50% with back-to-back 1-, 3- and 7-byte packets: byte order is preserved, data is held stable under stall, and tlast appears on bytes 1, 4 and 11.
- Traffic on endpoint 1 while P_ENDPOINT=2: no writes, no `pkt_drop`, `usb_rxrdy` unchanged.
